axi_llc_sram_port_ctrl: RTL and testbench



---
 rtl/axi_llc_pkg.sv | 24 ++
 rtl/axi_llc_sram_rsp_fifo.sv | 83 ++++++++
 rtl/axi_llc_sram_port_ctrl.sv | 149 ++++++++++++++
 tb/tb_axi_llc_sram_port_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_llc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axi_llc_pkg
// Brief    : Shared helpers for the LLC SRAM port controller and its FIFO.
// Revision : 1.0
// ============================================================================
package axi_llc_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } sram_op_e;

    function automatic int unsigned addr_width(input int unsigned num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    function automatic int unsigned be_width(input int unsigned data_width,
                                             input int unsigned byte_width);
        return (data_width + byte_width - 1) / byte_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_llc_sram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_sram_rsp_fifo
// Brief    : Registered response FIFO, simultaneous push/pop honoured when full.
// Revision : 1.0
// ============================================================================
module axi_llc_sram_rsp_fifo #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned WIDTH       = 128,
    parameter int unsigned USAGE_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [USAGE_WIDTH-1:0] usage_o
);

    localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0]   c_ptr_last   = PTR_WIDTH'(DEPTH - 1);
    localparam logic [USAGE_WIDTH-1:0] c_usage_full = USAGE_WIDTH'(DEPTH);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]   wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0]   rptr_q, rptr_d;
    logic [USAGE_WIDTH-1:0] usage_q, usage_d;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_do_push;
    logic                   w_do_pop;

    assign w_full    = (usage_q == c_usage_full);
    assign w_empty   = (usage_q == '0);
    assign w_do_pop  = pop_i & ~w_empty;
    // A pop frees the head slot on the same edge, so a full FIFO may still accept.
    assign w_do_push = push_i & (~w_full | w_do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        usage_d = usage_q;
        if (w_do_push) begin
            wptr_d = (wptr_q == c_ptr_last) ? '0 : wptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rptr_d = (rptr_q == c_ptr_last) ? '0 : rptr_q + 1'b1;
        end
        if (w_do_push && !w_do_pop) begin
            usage_d = usage_q + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            usage_d = usage_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            usage_q <= usage_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o  = w_empty ? '0 : mem_q[rptr_q];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign usage_o = usage_q;

endmodule
`default_nettype wire

// File: rtl/axi_llc_sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_sram_port_ctrl
// Brief    : Request stream to SRAM strobes, credit-guarded read return path.
// Revision : 1.0
// ============================================================================
module axi_llc_sram_port_ctrl
    import axi_llc_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned RSP_DEPTH  = 2,
    parameter int unsigned ADDR_WIDTH = addr_width(NUM_WORDS),
    parameter int unsigned BE_WIDTH   = be_width(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BE_WIDTH-1:0]   req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BE_WIDTH-1:0]   sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    output logic                  busy_o
);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } sram_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
    } sram_rsp_t;

    localparam int unsigned CREDIT_WIDTH = $clog2(RSP_DEPTH + 1);
    localparam logic [CREDIT_WIDTH-1:0] c_credit_max = CREDIT_WIDTH'(RSP_DEPTH);

    if (LATENCY < 1) begin : g_bad_latency
        $fatal(1, "LATENCY must be at least 1");
    end
    if (RSP_DEPTH < 1) begin : g_bad_depth
        $fatal(1, "RSP_DEPTH must be at least 1");
    end

    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic [LATENCY-1:0]      vld_q, vld_d;
    logic [CREDIT_WIDTH-1:0] w_usage;
    logic                    w_ready;
    logic                    w_sram_req;
    logic                    w_rd_hs;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_full;
    logic                    w_empty;
    sram_req_t               w_req_in;
    sram_rsp_t               w_rsp_in;
    sram_rsp_t               w_rsp_out;

    assign w_ready    = (credits_q != '0);
    assign w_sram_req = req_valid_i & w_ready;
    assign w_rd_hs    = w_sram_req & (req_we_i == OP_READ);
    assign w_pop      = ~w_empty & rsp_ready_i;
    assign w_push     = vld_q[LATENCY-1];

    assign w_req_in = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};

    // Every accepted read reserves a FIFO slot until its response is popped.
    always_comb begin
        credits_d = credits_q;
        if (w_rd_hs && !w_pop) begin
            credits_d = credits_q - 1'b1;
        end else if (!w_rd_hs && w_pop) begin
            credits_d = credits_q + 1'b1;
        end
    end

    if (LATENCY == 1) begin : g_lat_one
        assign vld_d = w_rd_hs;
    end else begin : g_lat_multi
        assign vld_d = {vld_q[LATENCY-2:0], w_rd_hs};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits_q <= c_credit_max;
            vld_q     <= '0;
        end else begin
            credits_q <= credits_d;
            vld_q     <= vld_d;
        end
    end

    assign w_rsp_in.rdata = sram_rdata_i;

    axi_llc_sram_rsp_fifo #(
        .DEPTH       (RSP_DEPTH),
        .WIDTH       ($bits(sram_rsp_t)),
        .USAGE_WIDTH (CREDIT_WIDTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (w_rsp_in),
        .pop_i   (w_pop),
        .data_o  (w_rsp_out),
        .full_o  (w_full),
        .empty_o (w_empty),
        .usage_o (w_usage)
    );

    assign req_ready_o  = w_ready;
    assign sram_req_o   = w_sram_req;
    assign sram_we_o    = w_sram_req & w_req_in.we;
    assign sram_addr_o  = w_sram_req ? w_req_in.addr  : '0;
    assign sram_wdata_o = w_sram_req ? w_req_in.wdata : '0;
    assign sram_be_o    = w_sram_req ? w_req_in.be    : '0;
    assign rsp_valid_o  = ~w_empty;
    assign rsp_rdata_o  = w_rsp_out.rdata;
    assign busy_o       = (|vld_q) | ~w_empty;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (sram_req_o) begin
                assert (32'(sram_addr_o) < NUM_WORDS)
                else $warning("SRAM address %0d beyond %0d words", sram_addr_o, NUM_WORDS);
            end
            assert (int'(credits_q) + int'(w_usage) + $countones(vld_q) == int'(RSP_DEPTH))
            else $error("credit accounting out of balance");
            assert (!(w_push && w_full && !w_pop))
            else $error("response FIFO overflow");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_llc_sram_port_ctrl
// Brief    : Two-configuration bench with SRAM models and a credit-level reference.
// Revision : 1.0
// ============================================================================
module tb_axi_llc_sram_port_ctrl;

    localparam int LAT_A = 1;
    localparam int DEP_A = 2;
    localparam int LAT_B = 2;
    localparam int DEP_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: LATENCY 1, depth 2, 128-bit
    logic         a_req_valid = 0, a_req_we = 0, a_rsp_ready = 0;
    logic [5:0]   a_req_addr = '0;
    logic [127:0] a_req_wdata = '0;
    logic [15:0]  a_req_be = '0;
    logic         a_req_ready, a_rsp_valid, a_sram_req, a_sram_we, a_busy;
    logic [127:0] a_rsp_rdata, a_sram_wdata, a_sram_rdata;
    logic [5:0]   a_sram_addr;
    logic [15:0]  a_sram_be;

    // instance B: LATENCY 2, depth 3, 32-bit
    logic         b_req_valid = 0, b_req_we = 0, b_rsp_ready = 0;
    logic [5:0]   b_req_addr = '0;
    logic [31:0]  b_req_wdata = '0;
    logic [3:0]   b_req_be = '0;
    logic         b_req_ready, b_rsp_valid, b_sram_req, b_sram_we, b_busy;
    logic [31:0]  b_rsp_rdata, b_sram_wdata, b_sram_rdata;
    logic [5:0]   b_sram_addr;
    logic [3:0]   b_sram_be;

    axi_llc_sram_port_ctrl #(
        .NUM_WORDS(64), .DATA_WIDTH(128), .BYTE_WIDTH(8), .LATENCY(LAT_A), .RSP_DEPTH(DEP_A)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata),
        .sram_req_o(a_sram_req), .sram_we_o(a_sram_we), .sram_addr_o(a_sram_addr),
        .sram_wdata_o(a_sram_wdata), .sram_be_o(a_sram_be), .sram_rdata_i(a_sram_rdata),
        .busy_o(a_busy)
    );

    axi_llc_sram_port_ctrl #(
        .NUM_WORDS(64), .DATA_WIDTH(32), .BYTE_WIDTH(8), .LATENCY(LAT_B), .RSP_DEPTH(DEP_B)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
        .sram_req_o(b_sram_req), .sram_we_o(b_sram_we), .sram_addr_o(b_sram_addr),
        .sram_wdata_o(b_sram_wdata), .sram_be_o(b_sram_be), .sram_rdata_i(b_sram_rdata),
        .busy_o(b_busy)
    );

    // SRAM behavioural models with fixed read latency
    logic [127:0] mem_a [64];
    logic [31:0]  mem_b [64];
    logic [31:0]  b_rd0;

    always @(posedge clk) begin
        if (a_sram_req) begin
            if (a_sram_we) begin
                for (int k = 0; k < 16; k++)
                    if (a_sram_be[k]) mem_a[a_sram_addr][k*8 +: 8] <= a_sram_wdata[k*8 +: 8];
            end else begin
                a_sram_rdata <= mem_a[a_sram_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (b_sram_req) begin
            if (b_sram_we) begin
                for (int k = 0; k < 4; k++)
                    if (b_sram_be[k]) mem_b[b_sram_addr][k*8 +: 8] <= b_sram_wdata[k*8 +: 8];
            end else begin
                b_rd0 <= mem_b[b_sram_addr];
            end
        end
        b_sram_rdata <= b_rd0;
    end

    // Reference contents as seen through accepted request-level writes
    logic [127:0] ref_a [64];
    logic [31:0]  ref_b [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_a();
        int           out = 0;
        logic [127:0] q_dat [$];
        int           q_t [$];
        logic         hold = 0;
        logic [127:0] hold_dat = '0;
        logic         exp_rdy, rd, pop;
        logic [151:0] exp_bus, got_bus;
        forever begin
            @(negedge clk);
            if (rst) begin
                out = 0; q_dat.delete(); q_t.delete(); hold = 0;
            end else begin
                exp_rdy = (out < DEP_A);
                total++;
                if (a_req_ready !== exp_rdy) begin
                    bad++; $display("FAIL a_req_ready: got=%b exp=%b cyc=%0d", a_req_ready, exp_rdy, cyc);
                end
                exp_bus = (a_req_valid && exp_rdy) ? {1'b1, a_req_we, a_req_addr, a_req_wdata, a_req_be} : '0;
                got_bus = {a_sram_req, a_sram_we, a_sram_addr, a_sram_wdata, a_sram_be};
                total++;
                if (got_bus !== exp_bus) begin
                    bad++; $display("FAIL a_sram_drive: got=%h exp=%h cyc=%0d", got_bus, exp_bus, cyc);
                end
                total++;
                if (a_busy !== (out != 0)) begin
                    bad++; $display("FAIL a_busy: got=%b exp=%b cyc=%0d", a_busy, (out != 0), cyc);
                end
                if (hold) begin
                    total++;
                    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== hold_dat) begin
                        bad++; $display("FAIL a_rsp_hold: got=%b/%h exp=1/%h cyc=%0d", a_rsp_valid, a_rsp_rdata, hold_dat, cyc);
                    end
                end
                rd  = a_req_valid && a_req_ready && !a_req_we;
                pop = a_rsp_valid && a_rsp_ready;
                if (pop) begin
                    total++;
                    if (q_dat.size() == 0) begin
                        bad++; $display("FAIL a_rsp_spurious: got=%h exp=none cyc=%0d", a_rsp_rdata, cyc);
                    end else if (a_rsp_rdata !== q_dat[0] || cyc < q_t[0] + LAT_A + 1) begin
                        bad++; $display("FAIL a_rsp_data: got=%h exp=%h cyc=%0d accepted=%0d", a_rsp_rdata, q_dat[0], cyc, q_t[0]);
                    end
                    if (q_dat.size() != 0) begin
                        void'(q_dat.pop_front()); void'(q_t.pop_front());
                    end
                end
                if (a_req_valid && a_req_ready && a_req_we)
                    for (int k = 0; k < 16; k++)
                        if (a_req_be[k]) ref_a[a_req_addr][k*8 +: 8] = a_req_wdata[k*8 +: 8];
                if (rd) begin
                    q_dat.push_back(ref_a[a_req_addr]); q_t.push_back(cyc);
                end
                out = out + int'(rd) - int'(pop);
                total++;
                if (out < 0 || out > DEP_A) begin
                    bad++; $display("FAIL a_credit_range: got=%0d exp=0..%0d cyc=%0d", out, DEP_A, cyc);
                end
                hold = a_rsp_valid && !a_rsp_ready;
                hold_dat = a_rsp_rdata;
            end
        end
    endtask

    task automatic mon_b();
        int          out = 0;
        logic [31:0] q_dat [$];
        int          q_t [$];
        logic        hold = 0;
        logic [31:0] hold_dat = '0;
        logic        exp_rdy, rd, pop;
        logic [43:0] exp_bus, got_bus;
        forever begin
            @(negedge clk);
            if (rst) begin
                out = 0; q_dat.delete(); q_t.delete(); hold = 0;
            end else begin
                exp_rdy = (out < DEP_B);
                total++;
                if (b_req_ready !== exp_rdy) begin
                    bad++; $display("FAIL b_req_ready: got=%b exp=%b cyc=%0d", b_req_ready, exp_rdy, cyc);
                end
                exp_bus = (b_req_valid && exp_rdy) ? {1'b1, b_req_we, b_req_addr, b_req_wdata, b_req_be} : '0;
                got_bus = {b_sram_req, b_sram_we, b_sram_addr, b_sram_wdata, b_sram_be};
                total++;
                if (got_bus !== exp_bus) begin
                    bad++; $display("FAIL b_sram_drive: got=%h exp=%h cyc=%0d", got_bus, exp_bus, cyc);
                end
                total++;
                if (b_busy !== (out != 0)) begin
                    bad++; $display("FAIL b_busy: got=%b exp=%b cyc=%0d", b_busy, (out != 0), cyc);
                end
                if (hold) begin
                    total++;
                    if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== hold_dat) begin
                        bad++; $display("FAIL b_rsp_hold: got=%b/%h exp=1/%h cyc=%0d", b_rsp_valid, b_rsp_rdata, hold_dat, cyc);
                    end
                end
                rd  = b_req_valid && b_req_ready && !b_req_we;
                pop = b_rsp_valid && b_rsp_ready;
                if (pop) begin
                    total++;
                    if (q_dat.size() == 0) begin
                        bad++; $display("FAIL b_rsp_spurious: got=%h exp=none cyc=%0d", b_rsp_rdata, cyc);
                    end else if (b_rsp_rdata !== q_dat[0] || cyc < q_t[0] + LAT_B + 1) begin
                        bad++; $display("FAIL b_rsp_data: got=%h exp=%h cyc=%0d accepted=%0d", b_rsp_rdata, q_dat[0], cyc, q_t[0]);
                    end
                    if (q_dat.size() != 0) begin
                        void'(q_dat.pop_front()); void'(q_t.pop_front());
                    end
                end
                if (b_req_valid && b_req_ready && b_req_we)
                    for (int k = 0; k < 4; k++)
                        if (b_req_be[k]) ref_b[b_req_addr][k*8 +: 8] = b_req_wdata[k*8 +: 8];
                if (rd) begin
                    q_dat.push_back(ref_b[b_req_addr]); q_t.push_back(cyc);
                end
                out = out + int'(rd) - int'(pop);
                total++;
                if (out < 0 || out > DEP_B) begin
                    bad++; $display("FAIL b_credit_range: got=%0d exp=0..%0d cyc=%0d", out, DEP_B, cyc);
                end
                hold = b_rsp_valid && !b_rsp_ready;
                hold_dat = b_rsp_rdata;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({a_req_ready, a_rsp_valid, a_busy, a_sram_req, a_sram_we} !== 5'b10000) begin
            bad++; $display("FAIL reset_a_ctrl: got=%b exp=10000", {a_req_ready, a_rsp_valid, a_busy, a_sram_req, a_sram_we});
        end
        total++;
        if (a_rsp_rdata !== '0 || a_sram_addr !== '0 || a_sram_wdata !== '0 || a_sram_be !== '0) begin
            bad++; $display("FAIL reset_a_data: got rdata=%h addr=%h exp=0", a_rsp_rdata, a_sram_addr);
        end
        total++;
        if ({b_req_ready, b_rsp_valid, b_busy, b_sram_req, b_sram_we} !== 5'b10000 || b_rsp_rdata !== '0) begin
            bad++; $display("FAIL reset_b: got=%b rdata=%h exp=10000/0", {b_req_ready, b_rsp_valid, b_busy, b_sram_req, b_sram_we}, b_rsp_rdata);
        end
        tick();
    endtask

    task automatic test_write_read();
        logic [127:0] pat = {16{8'hA5}};
        a_rsp_ready = 1; a_req_valid = 1; a_req_we = 1; a_req_addr = 6'd5;
        a_req_wdata = pat; a_req_be = '1;
        @(negedge clk);
        total++;
        if ({a_sram_req, a_sram_we} !== 2'b11 || a_sram_addr !== 6'd5) begin
            bad++; $display("FAIL wr_cycle0: got req/we=%b addr=%0d exp=11/5", {a_sram_req, a_sram_we}, a_sram_addr);
        end
        tick();
        a_req_we = 0;
        @(negedge clk);
        total++;
        if ({a_sram_req, a_sram_we} !== 2'b10 || a_sram_addr !== 6'd5) begin
            bad++; $display("FAIL rd_cycle1: got req/we=%b addr=%0d exp=10/5", {a_sram_req, a_sram_we}, a_sram_addr);
        end
        tick();
        a_req_valid = 0;
        @(negedge clk);
        total++;
        if (a_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rsp_cycle2: got valid=%b exp=0", a_rsp_valid);
        end
        tick();
        @(negedge clk);
        total++;
        if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== pat) begin
            bad++; $display("FAIL rsp_cycle3: got valid=%b data=%h exp=1/%h", a_rsp_valid, a_rsp_rdata, pat);
        end
        tick();
        @(negedge clk);
        total++;
        if (a_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rsp_cycle4: got valid=%b exp=0", a_rsp_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int acc = 0, pops = 0, n = 0;
        a_rsp_ready = 1;
        for (int i = 0; i < 8; i++) begin
            a_req_valid = 1; a_req_we = 1; a_req_addr = 6'(i); a_req_be = '1;
            a_req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        a_req_we = 0;
        while ((acc < 8 || pops < 8) && n < 60) begin
            a_req_valid = (acc < 8);
            a_req_addr  = 6'(acc);
            @(negedge clk);
            if (a_req_valid && a_req_ready) acc++;
            if (a_rsp_valid && a_rsp_ready) pops++;
            tick();
            n++;
        end
        a_req_valid = 0;
        total++;
        if (acc != 8 || pops != 8) begin
            bad++; $display("FAIL b2b_count: got acc=%0d pops=%0d exp=8/8", acc, pops);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0, pops = 0, n = 0;
        a_rsp_ready = 0; a_req_we = 0;
        for (int c = 0; c < 8; c++) begin
            a_req_valid = 1; a_req_addr = 6'(acc);
            @(negedge clk);
            if (a_req_ready) acc++;
            tick();
        end
        @(negedge clk);
        total++;
        if (acc != DEP_A || a_req_ready !== 1'b0 || a_sram_req !== 1'b0) begin
            bad++; $display("FAIL bp_stall: got acc=%0d ready=%b exp=%0d/0", acc, a_req_ready, DEP_A);
        end
        tick();
        a_rsp_ready = 1;
        while ((acc < 8 || pops < 8) && n < 80) begin
            a_req_valid = (acc < 8); a_req_addr = 6'(acc);
            @(negedge clk);
            if (a_req_valid && a_req_ready) acc++;
            if (a_rsp_valid && a_rsp_ready) pops++;
            tick();
            n++;
        end
        a_req_valid = 0;
        total++;
        if (acc != 8 || pops != 8) begin
            bad++; $display("FAIL bp_drain: got acc=%0d pops=%0d exp=8/8", acc, pops);
        end
    endtask

    task automatic test_random_b();
        int nrd = 0, nboth = 0, n = 0;
        for (int i = 0; i < 16; i++) begin
            b_req_valid = 1; b_req_we = 1; b_req_addr = 6'(i); b_req_be = '1;
            b_req_wdata = $urandom();
            tick();
        end
        for (int c = 0; c < 300; c++) begin
            b_req_valid = ($urandom_range(0, 9) < 7);
            b_req_we    = ($urandom_range(0, 3) == 0);
            b_req_addr  = 6'($urandom_range(0, 15));
            b_req_wdata = $urandom();
            b_req_be    = 4'($urandom_range(0, 15));
            b_rsp_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (b_req_valid && b_req_ready && !b_req_we) begin
                nrd++;
                if (b_rsp_valid && b_rsp_ready) nboth++;
            end
            tick();
        end
        b_req_valid = 0; b_rsp_ready = 1;
        while (b_busy !== 1'b0 && n < 30) begin
            tick();
            n++;
        end
        @(negedge clk);
        total++;
        if (nrd < 10 || nboth == 0 || b_busy !== 1'b0 || b_req_ready !== 1'b1) begin
            bad++; $display("FAIL rand_b: got reads=%0d overlap=%0d busy=%b ready=%b exp>=10/>0/0/1", nrd, nboth, b_busy, b_req_ready);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        a_rsp_ready = 0; a_req_valid = 1; a_req_we = 0; a_req_addr = 6'd1;
        @(negedge clk);
        total++;
        if (a_req_ready !== 1'b1) begin
            bad++; $display("FAIL mid_accept: got ready=%b exp=1", a_req_ready);
        end
        tick();
        a_req_addr = 6'd2;
        tick();
        a_req_valid = 0; rst = 1;
        @(negedge clk);
        total++;
        if (a_rsp_valid !== 1'b1 || a_busy !== 1'b1) begin
            bad++; $display("FAIL mid_queued: got valid=%b busy=%b exp=1/1", a_rsp_valid, a_busy);
        end
        tick();
        rst = 0; a_rsp_ready = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0) begin
                bad++; $display("FAIL mid_after_rst: got valid=%b ready=%b busy=%b exp=0/1/0 c=%0d", a_rsp_valid, a_req_ready, a_busy, c);
            end
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        fork
            mon_a();
            mon_b();
        join_none
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_random_b();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
